// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the sequential 16/8 restoring divider.
// Build option: DIV_SEQ_APPROX_EN enables the approximate low-order rows.
package div_ctrl_pkg;

  localparam int unsigned XW        = 16;
  localparam int unsigned YW        = 8;
  localparam int unsigned STEPS     = 8;
  localparam int unsigned APX_START = 4;
  localparam int unsigned APX_MAX   = 4;
  localparam int unsigned KW        = 3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Number of approximated LSBs for row s; 0 means the row is exact.
  function automatic logic [KW-1:0] row_k(input int unsigned s, input int unsigned apx_start,
                                          input bit en);
    int unsigned k;
    k = 0;
    if (en && s >= apx_start) k = s - apx_start + 1;
    if (k > APX_MAX) k = APX_MAX;
    return k[KW-1:0];
  endfunction

endpackage

// File: rtl/div_row.sv
// One restoring-divider row: 9-bit partial remainder minus 8-bit divisor.
// k > 0 replaces the k low cells by pass-through, with y[k-1] as borrow into bit k.
module div_row
  import div_ctrl_pkg::*;
(
  input  logic [YW:0]   x9,
  input  logic [YW-1:0] y,
  input  logic [KW-1:0] k,
  output logic          qs,
  output logic [YW-1:0] r8
);

  localparam logic [KW-1:0] KOne = KW'(1);

  logic [YW-1:0] d;
  logic          b;

  always_comb begin
    d  = '0;
    b  = 1'b0;
    qs = 1'b0;
    r8 = '0;
    for (int i = 0; i < int'(YW); i++) begin
      // Borrow out of the approximated cells is not computed; it is estimated from y.
      if (k != '0 && i == int'(k)) b = y[k - KOne];
      d[i] = x9[i] ^ y[i] ^ b;
      b    = (~x9[i] & y[i]) | (~(x9[i] ^ y[i]) & b);
    end
    qs = ~b | x9[YW];
    for (int i = 0; i < int'(YW); i++) begin
      r8[i] = (i < int'(k)) ? x9[i] : (qs ? d[i] : x9[i]);
    end
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Iterative divider sequencer: one row per clock, eight rows per division.
// Build option: DIV_SEQ_APPROX_EN makes rows APX_START..7 approximate (k = 1..4).
module div_seq_ctrl #(
  parameter int unsigned STEPS     = div_ctrl_pkg::STEPS,
  parameter int unsigned APX_START = div_ctrl_pkg::APX_START
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [div_ctrl_pkg::XW-1:0] dividend,
  input  logic [div_ctrl_pkg::YW-1:0] divisor,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [div_ctrl_pkg::YW-1:0] quotient,
  output logic [div_ctrl_pkg::YW-1:0] remainder,
  output logic                        ovf,
  output logic                        busy
);

  import div_ctrl_pkg::*;

  localparam int unsigned CW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned SW = XW - YW - 1;
  localparam logic [CW-1:0] LastRow = CW'(STEPS - 1);

`ifdef DIV_SEQ_APPROX_EN
  localparam bit ApxEn = 1'b1;
`else
  localparam bit ApxEn = 1'b0;
`endif

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [YW:0]   p_q;
  logic [SW-1:0] xs_q;
  logic [YW-1:0] y_q;

  logic [KW-1:0] row_k_s;
  logic          row_qs;
  logic [YW-1:0] row_r8;

  assign row_k_s = row_k(32'(cnt_q), APX_START, ApxEn);

  div_row u_row (
    .x9 (p_q),
    .y  (y_q),
    .k  (row_k_s),
    .qs (row_qs),
    .r8 (row_r8)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      p_q       <= '0;
      xs_q      <= '0;
      y_q       <= '0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            y_q     <= divisor;
            p_q     <= dividend[XW-1:YW-1];
            xs_q    <= dividend[SW-1:0];
            ovf     <= (dividend[XW-1:YW] >= divisor);
            cnt_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          quotient[LastRow - cnt_q] <= row_qs;
          cnt_q                     <= cnt_q + 1'b1;
          if (cnt_q == LastRow) begin
            remainder <= row_r8;
            state_q   <= StDone;
          end else begin
            p_q  <= {row_r8, xs_q[SW-1]};
            xs_q <= {xs_q[SW-2:0], 1'b0};
          end
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Handshake flags depend only on state, never on in_valid/out_ready.
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StRun);

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl against an arithmetic row model.
// Honours DIV_SEQ_APPROX_EN to select the approximate reference.
module tb_div_seq_ctrl;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       ovf;
    int         rise;
  } exp_t;

`ifdef DIV_SEQ_APPROX_EN
  localparam bit Apx = 1'b1;
`else
  localparam bit Apx = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        ovf;
  logic        busy;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   rand_rdy = 1'b0;

  div_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Row as arithmetic on the upper field: (x >> k) - (y >> k) - y[k-1].
  function automatic void row_model(input logic [8:0] x9, input logic [7:0] y, input int k,
                                    output bit qs, output logic [7:0] r8);
    int xh, yh, bin, diff, hi;
    xh   = int'(x9[7:0]) >> k;
    yh   = int'(y) >> k;
    bin  = (k == 0) ? 0 : int'(y[k-1]);
    diff = xh - yh - bin;
    qs   = (diff >= 0) || x9[8];
    hi   = qs ? (diff & ((1 << (8 - k)) - 1)) : xh;
    r8   = 8'((hi << k) | (int'(x9[7:0]) & ((1 << k) - 1)));
  endfunction

  function automatic exp_t model(input logic [15:0] x, input logic [7:0] y);
    exp_t       e;
    logic [8:0] p;
    logic [7:0] r8;
    bit         qs;
    int         k;
    e.q  = '0;
    e.r  = '0;
    p    = x[15:7];
    for (int s = 0; s < 8; s++) begin
      k = (Apx && s >= 4) ? s - 3 : 0;
      row_model(p, y, k, qs, r8);
      e.q[7-s] = qs;
      if (s < 7) p = {r8, x[6-s]};
      else e.r = r8;
    end
    e.ovf  = (x[15:8] >= y);
    e.rise = 0;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // mode 0: model only; 1: q/r/ovf from constants; 2: ovf from constant.
  task automatic issue(input logic [15:0] x, input logic [7:0] y, input int mode,
                       input logic [7:0] cq, input logic [7:0] cr, input logic covf);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1;
    dividend = x;
    divisor  = y;
    e = model(x, y);
    if (mode == 1) begin
      e.q = cq;
      e.r = cr;
    end
    if (mode != 0) e.ovf = covf;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    e.rise   = cyc + 8;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  // Monitor: latency on out_valid rise, result on each output handshake.
  initial begin
    bit   prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        prev = 1'b0;
      end else begin
        if (out_valid && !prev) begin
          if (exp_q.size() == 0) check("unexpected_out", 32'(out_valid), 32'd0);
          else check("latency", 32'(cyc), 32'(exp_q[0].rise));
        end
        if (out_valid && out_ready && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("result", {12'd0, quotient, remainder, ovf}, {12'd0, e.q, e.r, e.ovf});
        end
        prev = out_valid;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic [16:0] hold;
    logic [7:0]  y;
    logic [7:0]  hi;
    int          n;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_state", {12'd0, in_ready, out_valid, busy, quotient, remainder, ovf},
          {12'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    out_ready = 1'b1;
`ifdef DIV_SEQ_APPROX_EN
    issue(16'd1000, 8'd7, 0, 8'd0, 8'd0, 1'b0);
`else
    issue(16'd1000, 8'd7, 1, 8'd142, 8'd6, 1'b0);
`endif
    issue(16'h0300, 8'h10, 1, 8'd48, 8'd0, 1'b0);
    issue(16'h1234, 8'h00, 2, 8'd0, 8'd0, 1'b1);
    issue(16'h0800, 8'h08, 2, 8'd0, 8'd0, 1'b1);
    issue(16'h07ff, 8'h08, 2, 8'd0, 8'd0, 1'b0);
    drain();

    // Back-pressure: five stalled cycles with in_valid toggling, then handshake.
    out_ready = 1'b0;
    issue(16'h1234, 8'h9a, 0, 8'd0, 8'd0, 1'b0);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid", 32'(out_valid), 32'd1);
    hold = {quotient, remainder, ovf};
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      dividend = 16'($urandom);
      divisor  = 8'($urandom);
      @(negedge clk);
      check("bp_stable", 32'({quotient, remainder, ovf}), 32'(hold));
      check("bp_flags", {29'd0, in_ready, out_valid, busy}, {29'd0, 1'b0, 1'b1, 1'b0});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_release", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
    drain();

    // Asynchronous abort in the middle of a division.
    out_ready = 1'b1;
    issue(16'hbeef, 8'hc5, 0, 8'd0, 8'd0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("abort_state", {12'd0, in_ready, out_valid, busy, quotient, remainder, ovf},
          {12'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
`ifdef DIV_SEQ_APPROX_EN
    issue(16'd1000, 8'd7, 0, 8'd0, 8'd0, 1'b0);
`else
    issue(16'd1000, 8'd7, 1, 8'd142, 8'd6, 1'b0);
`endif
    drain();

    // Random sweep of non-overflow operands with random consumer stalls.
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      y  = 8'($urandom_range(1, 255));
      hi = 8'($urandom_range(0, int'(y) - 1));
      issue({hi, 8'($urandom_range(0, 255))}, y, 0, 8'd0, 8'd0, 1'b0);
    end
    drain();
    rand_rdy = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: time %0t reached without finishing", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/div_seq_ctrl.md
# div_seq_ctrl

Iterative sequencer for the 16/8 restoring array divider. It evaluates one divider row per clock, reusing a single row instance eight times instead of instantiating eight rows. It accepts operands over a valid/ready handshake and applies the per-row approximation schedule: last four rows approximate 1..4 LSBs. It returns quotient, remainder and an overflow flag over a second valid/ready handshake. It sits between the operand source and any consumer of divider results.

## Interface
- `STEPS`, 8: rows per division, equal to the quotient width.
- `APX_START`, 4: index of the first approximate row; row s ≥ APX_START approximates k = s − APX_START + 1 LSBs.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  operands present.
- `in_ready`  out  1  block idle, operands accepted.
- `dividend`  in  16  dividend x.
- `divisor`  in  8  divisor y.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer takes result.
- `quotient`  out  8  q.
- `remainder`  out  8  r.
- `ovf`  out  1  dividend[15:8] ≥ divisor (includes divisor = 0); quotient/remainder then undefined-by-design but deterministic.
- `busy`  out  1  state is RUN.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid` && `in_ready`:
    - latch divisor into `y_q`;
    - latch dividend[15:7] into the 9-bit partial remainder `p`;
    - latch dividend[6:0] into the shift register `xs`;
    - compute and latch `ovf`;
    - clear `cnt` to 0;
    - go to RUN.
- **RUN**, row s = `cnt` (0..7):
  - Row input is x9 = `p`.
  - Exact row:
    - d = x9[7:0] − y − 0, with borrow chain b8;
    - qs = ~b8 | x9[8];
    - r8 = qs ? d : x9[7:0].
  - Approximate row with k LSBs:
    - borrow into bit k = y[k−1];
    - r8[k−1:0] = x9[k−1:0] regardless of qs;
    - bits k..7 use the exact cell.
  - Each row records qs into quotient bit 7−s.
  - If s < 7: `p` ← {r8, `xs`[6]}, and `xs` shifts left by one.
  - If s = 7: remainder ← r8, go to DONE.
  - `cnt` increments every RUN cycle.
- **DONE**
  - `out_valid` = 1; `quotient`, `remainder` and `ovf` are held stable.
  - On `out_ready`: go to IDLE.
  - No same-cycle accept; `in_ready` is 0 in DONE.
- Reset, or `rst_n` low mid-RUN or mid-DONE:
  - abort immediately, state IDLE;
  - `cnt`, `p`, `xs`, `y_q`, `quotient`, `remainder` and `ovf` all go to 0.
- `in_valid` during RUN or DONE is ignored; the source must hold its operands.

## Timing
- Reset values: `in_ready` = 1, `out_valid` = 0, `busy` = 0, `quotient` = 0, `remainder` = 0, `ovf` = 0.
- Accept edge E0 → rows 0..7 evaluated at edges E1..E8.
- `out_valid` is high from E8 until the edge where `out_ready` is sampled high. Fixed latency: 8 cycles.
- `in_ready` is 1 again in the cycle after the output handshake. Minimum throughput: one division per 10 cycles.
- `out_ready` held high before E8 → result consumed at E9.
- `in_ready`, `out_valid` and `busy` decode directly from state registers, with no combinational path from `in_valid` or `out_ready`.

## Configuration
- Macro: `DIV_SEQ_APPROX_EN`.
- Defined: rows `APX_START`..7 use the approximate cells with k = 1..4.
- Undefined: all eight rows are exact, `APX_START` is ignored, and results are exact restoring division for non-`ovf` inputs.

## Structure
- Package `div_ctrl_pkg` holds:
  - the state enum (IDLE/RUN/DONE);
  - constants `XW` = 16, `YW` = 8, `STEPS` = 8, `APX_START` = 4, `APX_MAX` = 4;
  - a function giving k for row s (0 for exact).
- One sub-module, `div_row`: a combinational 9-bit-in / 8-bit-out row with a k input (0..4) selecting approximate LSB cells. The controller instantiates it once.

## Test plan
- Macro undefined: dividend 1000 (0x03E8), divisor 7 → `out_valid` at E8, quotient 142, remainder 6, `ovf` 0.
- Macro defined: dividend 0x0300, divisor 0x10 → quotient 48, remainder 0, identical to exact. The divisor's low nibble is zero, so approximation is error-free.
- Divisor 0, or dividend 0x0800 with divisor 0x08 → `ovf` = 1, latency unchanged at 8 cycles.
- Back-pressure: `out_ready` low for 5 cycles after E8 → outputs stable, `in_ready` 0 and `in_valid` ignored throughout; handshake on cycle 6, then `in_ready` 1.
- `rst_n` pulsed low at `cnt` = 4 → all outputs 0 asynchronously, `in_ready` 1. The next division, 1000/7 with the macro undefined, gives 142 r 6.
- Random sweep of 1000 operand pairs with dividend[15:8] < divisor → quotient/remainder match a bit-accurate row model for the active macro setting, with no mismatches.
